// File: rtl/stream_decimator_pkg.sv
// Stream decimator shared definitions.
// Register map and field layout shared with the FIR control block.
package stream_decimator_pkg;

    localparam int ADDR_W = 12;

    localparam logic [ADDR_W-1:0] CTRL_OFS   = 12'h000;
    localparam logic [ADDR_W-1:0] STATUS_OFS = 12'h004;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_R_LSB     = 16;
    localparam int CTRL_R_MSB     = 31;
    localparam int STATUS_OVF_BIT = 0;
    localparam int STATUS_PH_LSB  = 16;
    localparam int STATUS_PH_MSB  = 31;

    localparam logic [31:0] CTRL_RESET = 32'h0001_0000;

    typedef struct packed {
        logic [15:0] ratio;
        logic        enable;
    } ctrl_t;

    // A zero ratio or a disabled block both mean "forward everything".
    function automatic logic [15:0] eff_ratio(input ctrl_t c);
        if (!c.enable || c.ratio == 16'd0) begin
            return 16'd1;
        end
        return c.ratio;
    endfunction

endpackage

// File: rtl/stream_decimator_if.sv
// Valid/ready sample stream used on both sides of the decimator.
// Master drives data and valid, slave drives ready.
interface stream_decimator_if #(
    parameter int DW = 16
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/stream_fifo_sync.sv
// Small synchronous FIFO for decimated samples.
// A push into a full FIFO succeeds only when a pop frees a slot that cycle.
module stream_fifo_sync #(
    parameter int DW    = 16,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          do_push;
    logic          do_pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head reads as zero when empty so no stale sample is ever exposed.
    assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (do_pop) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/stream_decimator.sv
// Keeps one sample in every R from the FIR output stream.
// AHB-Lite control: CTRL (enable, ratio) and STATUS (overflow, phase).
module stream_decimator
    import stream_decimator_pkg::*;
#(
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    stream_decimator_if.slave  s,
    stream_decimator_if.master m,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [31:0] hwdata,
    input  logic        hsel,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    ctrl_t             ctrl_q;
    logic              ovf_q;
    logic [15:0]       phase_q;
    logic              wr_pend_q;
    logic [ADDR_W-1:0] wr_addr_q;

    logic              addr_ph;
    logic              ctrl_wr;
    logic              ovf_w1c;
    logic              accept;
    logic              keep;
    logic              pop;
    logic              full;
    logic              empty;
    logic [15:0]       ratio;
    logic [31:0]       rd_val;
    logic              unused_bits;

    assign hreadyout = 1'b1;
    assign hresp     = 1'b0;

    assign unused_bits = ^{haddr[31:ADDR_W], htrans[0],
                           hwdata[CTRL_R_LSB-1:1]};

    assign addr_ph = hsel && htrans[1];
    assign ctrl_wr = wr_pend_q && (wr_addr_q == CTRL_OFS);
    assign ovf_w1c = wr_pend_q && (wr_addr_q == STATUS_OFS) &&
                     hwdata[STATUS_OVF_BIT];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            wr_pend_q <= addr_ph && hwrite;
            wr_addr_q <= haddr[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q.ratio  <= CTRL_RESET[CTRL_R_MSB:CTRL_R_LSB];
            ctrl_q.enable <= CTRL_RESET[CTRL_EN_BIT];
        end else if (ctrl_wr) begin
            ctrl_q.ratio  <= hwdata[CTRL_R_MSB:CTRL_R_LSB];
            ctrl_q.enable <= hwdata[CTRL_EN_BIT];
        end
    end

    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            (haddr[ADDR_W-1:0] == CTRL_OFS): begin
                rd_val[CTRL_R_MSB:CTRL_R_LSB] = ctrl_q.ratio;
                rd_val[CTRL_EN_BIT]           = ctrl_q.enable;
            end
            (haddr[ADDR_W-1:0] == STATUS_OFS): begin
                rd_val[STATUS_PH_MSB:STATUS_PH_LSB] = phase_q;
                rd_val[STATUS_OVF_BIT]              = ovf_q;
            end
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hrdata <= '0;
        end else if (addr_ph && !hwrite) begin
            hrdata <= rd_val;
        end else begin
            hrdata <= '0;
        end
    end

    assign s.tready = ce && reset_n;
    assign accept   = s.tvalid && s.tready;
    assign ratio    = eff_ratio(ctrl_q);
    assign keep     = accept && (phase_q == 16'd0);
    assign pop      = ce && m.tvalid && m.tready;

    // A ratio lowered below the running phase wraps on the next sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
        end else if (ctrl_wr) begin
            phase_q <= '0;
        end else if (accept) begin
            if (phase_q >= ratio - 16'd1) begin
                phase_q <= '0;
            end else begin
                phase_q <= phase_q + 16'd1;
            end
        end
    end

    // A new overflow wins over a coincident clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (keep && full && !pop) begin
            ovf_q <= 1'b1;
        end else if (ovf_w1c) begin
            ovf_q <= 1'b0;
        end
    end

    stream_fifo_sync #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (keep),
        .pop     (pop),
        .wdata   (s.tdata),
        .rdata   (m.tdata),
        .full    (full),
        .empty   (empty)
    );

    assign m.tvalid = !empty;

endmodule

// File: doc/stream_decimator.md
STREAM_DECIMATOR -- requirements
Module: stream_decimator

Interface
REQ-001 SHALL have parameter DW, default 16, sample width in bits (signed Q15 from the upstream FIR stage).
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, output buffer depth in entries (power of two, >= 2).
REQ-003 clk  input  1  clock, all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 ce  input  1  clock enable; gates all stream-side state.
REQ-006 s_tdata / s_tvalid / s_tready  in / in / out  DW / 1 / 1  AXI-Stream slave, fed from the FIR output.
REQ-007 m_tdata / m_tvalid / m_tready  out / out / in  DW / 1 / 1  AXI-Stream master, decimated samples.
REQ-008 haddr / htrans / hwrite / hwdata / hsel  in  32 / 2 / 1 / 32 / 1  AHB-Lite control slave inputs (hsize, hburst ignored).
REQ-009 hrdata / hreadyout / hresp  out  32 / 1 / 1  AHB-Lite slave outputs.

Function
REQ-010 CTRL at offset 0x00 SHALL hold bit0 = enable and [31:16] = ratio R; reset value 0x0001_0000.
REQ-011 STATUS at offset 0x04 SHALL hold bit0 = overflow (sticky, write-1-to-clear) and [31:16] = current phase; other bits read 0.
REQ-012 AHB address phase SHALL be captured when hsel && htrans[1]; write data SHALL be applied in the following data phase.
REQ-013 hreadyout SHALL be constant 1 and hresp constant 0 (OKAY); reads of unmapped offsets SHALL return 0; hrdata SHALL be registered.
REQ-014 R = 0 SHALL be treated as R = 1; enable = 0 SHALL behave as R = 1 (every sample forwarded).
REQ-015 s_tready SHALL be 1 whenever ce = 1 and reset is released; inputs are never back-pressured.
REQ-016 An input SHALL be accepted when ce && s_tvalid && s_tready.
REQ-017 The phase counter SHALL advance 0..R-1 on each accepted input and wrap to 0 after R-1.
REQ-018 The accepted sample SHALL be kept when phase = 0 and discarded otherwise.
REQ-019 Any CTRL write SHALL reset phase to 0 on the cycle the write is applied; the next accepted input is kept.
REQ-020 Kept samples SHALL be pushed into the FIFO; m_tvalid = FIFO not empty; m_tdata = FIFO head.
REQ-021 A pop SHALL occur on ce && m_tvalid && m_tready.
REQ-022 Latency: a kept sample accepted in cycle n into an empty FIFO SHALL appear on m_tdata with m_tvalid = 1 in cycle n+1.
REQ-023 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full; occupancy is unchanged.
REQ-024 A kept sample arriving while the FIFO is full with no pop SHALL be dropped and SHALL set overflow; FIFO contents are unchanged.
REQ-025 If a W1C of overflow coincides with a new overflow event, overflow SHALL remain 1.
REQ-026 While ce = 0, phase, FIFO and stream outputs SHALL hold their values; the AHB registers SHALL remain fully operational.
REQ-027 Output order SHALL equal input order; samples SHALL pass unmodified (no arithmetic, width DW preserved).

Reset
REQ-028 On reset_n low: m_tvalid = 0, m_tdata = 0, s_tready = 0, hrdata = 0, hreadyout = 1, hresp = 0.
REQ-029 On reset_n low: FIFO empty, phase = 0, overflow = 0, CTRL = 0x0001_0000.
REQ-030 Reset asserted mid-stream SHALL discard all buffered samples with no partial output.

Structure
REQ-031 Register offsets, CTRL/STATUS field bit positions and the CTRL reset value SHALL live in a shared package/header used with the FIR control map.
REQ-032 The output buffer SHALL be a sub-module, stream_fifo_sync (DW, FIFO_DEPTH, push/pop/full/empty, same-cycle push+pop when full).

Verification
REQ-033 R = 4, enable = 1, inputs 0..15 continuous, m_tready = 1 -> outputs 0, 4, 8, 12; each appears one cycle after its input.
REQ-034 enable = 0, inputs 0x1234, 0x8000 -> both forwarded unchanged, in order.
REQ-035 R = 1, m_tready = 0, 4 inputs -> first 2 held in FIFO, last 2 dropped, STATUS = 0x0000_0001; W1C to STATUS -> bit0 reads 0.
REQ-036 R = 3, accept 2 inputs, then write CTRL (R = 3) -> phase reads 0 and the next input is output.
REQ-037 ce toggling 1/0 every cycle, R = 2, inputs 0..7 -> outputs 0, 2, 4, 6; no state change in ce = 0 cycles.
REQ-038 reset_n pulsed low with 2 samples buffered -> m_tvalid = 0 immediately, CTRL reads 0x0001_0000, no stale output after release.
